// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one single-word SDRAM controller port between requester A
// (UART MCU) and requester B (Pi bus bridge); one transaction in flight, with a watchdog abort.
module sdram_port_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int TO_W   = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] WD_MAX  = {TO_W{1'b1}};

    state_t              state_r, state_s;
    logic                last_b_r, last_b_s;
    logic                gnt_b_r, gnt_b_s;
    logic [TO_W-1:0]     wd_r, wd_s, wd_inc_s;
    logic                take_b_s;
    logic [DATA_W-1:0]   resp_s;
    logic                mem_req_s, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                a_ack_s, b_ack_s, err_s;
    logic [DATA_W-1:0]   a_rdata_s, b_rdata_s;

    assign wd_inc_s = wd_r + WD_ONE;

    // Next-state and next-output computation for the grant/wait/done sequence.
    always_comb begin
        state_s     = state_r;
        last_b_s    = last_b_r;
        gnt_b_s     = gnt_b_r;
        wd_s        = wd_r;
        mem_req_s   = mem_req;
        mem_we_s    = mem_we;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        a_ack_s     = 1'b0;
        b_ack_s     = 1'b0;
        err_s       = 1'b0;
        a_rdata_s   = a_rdata;
        b_rdata_s   = b_rdata;
        resp_s      = {DATA_W{1'b0}};
        // B wins when it is alone, or when both ask and A was served last.
        take_b_s    = b_req & (~a_req | ~last_b_r);
        case (state_r)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_s     = ST_WAIT;
                    mem_req_s   = 1'b1;
                    mem_we_s    = take_b_s ? b_we : a_we;
                    mem_addr_s  = take_b_s ? b_addr : a_addr;
                    mem_wdata_s = take_b_s ? b_wdata : a_wdata;
                    last_b_s    = take_b_s;
                    gnt_b_s     = take_b_s;
                    wd_s        = WD_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A controller ack in the saturating cycle is a normal completion.
                if (mem_ack || (wd_inc_s == WD_MAX)) begin
                    state_s   = ST_DONE;
                    mem_req_s = 1'b0;
                    resp_s    = mem_ack ? mem_rdata : {DATA_W{1'b0}};
                    err_s     = ~mem_ack;
                    if (gnt_b_r) begin
                        b_ack_s   = 1'b1;
                        b_rdata_s = resp_s;
                    end else begin
                        a_ack_s   = 1'b1;
                        a_rdata_s = resp_s;
                    end
                end else begin
                    wd_s = wd_inc_s;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State, arbitration history and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            last_b_r  <= 1'b1;
            gnt_b_r   <= 1'b0;
            wd_r      <= WD_ZERO;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= {DATA_W{1'b0}};
            b_rdata   <= {DATA_W{1'b0}};
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_b_r  <= last_b_s;
            gnt_b_r   <= gnt_b_s;
            wd_r      <= wd_s;
            mem_req   <= mem_req_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            a_ack     <= a_ack_s;
            b_ack     <= b_ack_s;
            a_rdata   <= a_rdata_s;
            b_rdata   <= b_rdata_s;
            err       <= err_s;
            busy      <= (state_s != ST_IDLE);
        end
    end

endmodule
